// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue controller: FSM states, register-file geometry, scoreboard command.
// Pure declarations, no logic.
package issue_ctrl_pkg;

  localparam int cRegAddrW = 5;
  localparam int cNumRegs  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } tIssueState;

  typedef struct packed {
    logic                 set;
    logic [cRegAddrW-1:0] setAddr;
    logic                 clr;
    logic [cRegAddrW-1:0] clrAddr;
  } tScoreboardCmd;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoder/datapath side of the issue controller: issue handshake, writeback, flush/drain, status.
// master = decoder/datapath driving requests, slave = issue_ctrl.
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic                 iIssueValid;
  logic                 oIssueReady;
  logic [cRegAddrW-1:0] iRs1Addr;
  logic [cRegAddrW-1:0] iRs2Addr;
  logic                 iUsesRs1;
  logic                 iUsesRs2;
  logic [cRegAddrW-1:0] iRdAddr;
  logic                 iRdWe;
  logic                 iWbValid;
  logic [cRegAddrW-1:0] iWbAddr;
  logic                 iFlush;
  logic                 iDrainReq;
  logic                 oDrained;
  logic [3:0]           oInflight;
  logic [31:0]          oStallCnt;
  logic                 oErr;

  modport master (
    output iIssueValid, iRs1Addr, iRs2Addr, iUsesRs1, iUsesRs2, iRdAddr, iRdWe,
           iWbValid, iWbAddr, iFlush, iDrainReq,
    input  oIssueReady, oDrained, oInflight, oStallCnt, oErr
  );

  modport slave (
    input  iIssueValid, iRs1Addr, iRs2Addr, iUsesRs1, iUsesRs2, iRdAddr, iRdWe,
           iWbValid, iWbAddr, iFlush, iDrainReq,
    output oIssueReady, oDrained, oInflight, oStallCnt, oErr
  );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Busy-register scoreboard with set-over-clear priority and x0 tied idle; lookups are combinational.
// Lookups see the same-cycle writeback bypass; updates land on the next clock edge, no backpressure.
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRst,
  input  tScoreboardCmd        cmd,
  input  logic                 byp_vld,
  input  logic [cRegAddrW-1:0] byp_addr,
  input  logic [cRegAddrW-1:0] rs1_addr,
  input  logic [cRegAddrW-1:0] rs2_addr,
  input  logic [cRegAddrW-1:0] rd_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 byp_busy
);

  logic [cNumRegs-1:0] busy_q;
  logic [cNumRegs-1:0] busy_d;
  logic [cNumRegs-1:0] busy_eff;

  always_comb begin
    busy_d = busy_q;
    if (cmd.clr) busy_d[cmd.clrAddr] = 1'b0;
    if (cmd.set) busy_d[cmd.setAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Writeback retiring a register this cycle unblocks its readers/writers immediately.
  always_comb begin
    busy_eff = busy_q;
    if (byp_vld) busy_eff[byp_addr] = 1'b0;
  end

  assign rs1_busy = busy_eff[rs1_addr];
  assign rs2_busy = busy_eff[rs2_addr];
  assign rd_busy  = busy_eff[rd_addr];
  assign byp_busy = busy_q[byp_addr];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue gate between decoder and datapath: hazards, in-flight limit, flush bubbles, drain, stall/error status.
// Ready is combinational in the request cycle; status outputs are registered; decoder is held off via oIssueReady.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         iClk,
  input  logic         iRst,
  issue_ctrl_if.slave  bus
);

  localparam logic [3:0] cMaxInflight = 4'(MAX_INFLIGHT);
  localparam logic [2:0] cFlushLoad   = 3'(FLUSH_CYCLES - 1);

  tIssueState    state_q, state_d;
  logic [2:0]    flush_cnt_q, flush_cnt_d;
  logic [3:0]    inflight_q, inflight_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          err_q, err_d;
  logic          drained_q, drained_d;

  logic          rs1_busy, rs2_busy, rd_busy, wb_busy;
  logic          hazard, issue_rdy, fire, wb_err;
  tScoreboardCmd sb_cmd;

  issue_ctrl_scoreboard u_scoreboard (
    .iClk     (iClk),
    .iRst     (iRst),
    .cmd      (sb_cmd),
    .byp_vld  (bus.iWbValid),
    .byp_addr (bus.iWbAddr),
    .rs1_addr (bus.iRs1Addr),
    .rs2_addr (bus.iRs2Addr),
    .rd_addr  (bus.iRdAddr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .byp_busy (wb_busy)
  );

  always_comb begin
    hazard    = (bus.iUsesRs1 && rs1_busy) || (bus.iUsesRs2 && rs2_busy) || (bus.iRdWe && rd_busy);
    issue_rdy = !iRst && (state_q == RUN) && !bus.iFlush &&
                ((inflight_q < cMaxInflight) || bus.iWbValid) && !hazard;
    fire      = bus.iIssueValid && issue_rdy;
  end

  always_comb begin
    sb_cmd.set     = fire && bus.iRdWe && (bus.iRdAddr != '0);
    sb_cmd.setAddr = bus.iRdAddr;
    sb_cmd.clr     = bus.iWbValid;
    sb_cmd.clrAddr = bus.iWbAddr;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (bus.iFlush) begin
          state_d     = FLUSH;
          flush_cnt_d = cFlushLoad;
        end else if (bus.iDrainReq) begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        if (bus.iFlush)                 flush_cnt_d = cFlushLoad;
        else if (flush_cnt_q == 3'd0)   state_d     = RUN;
        else                            flush_cnt_d = flush_cnt_q - 3'd1;
      end
      DRAIN: begin
        if (!bus.iDrainReq) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    // Writeback to x0 is legal (non-writing instructions retire there); only empty pipe or idle reg is an error.
    wb_err = bus.iWbValid && ((inflight_q == 4'd0) || ((bus.iWbAddr != '0) && !wb_busy));

    inflight_d = inflight_q;
    if (fire && !bus.iWbValid)                           inflight_d = inflight_q + 4'd1;
    else if (bus.iWbValid && !fire && inflight_q != 4'd0) inflight_d = inflight_q - 4'd1;

    err_d = err_q || wb_err;

    stall_cnt_d = stall_cnt_q;
    if (bus.iIssueValid && !issue_rdy && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;

    drained_d = (state_d == DRAIN) && (inflight_d == 4'd0);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      drained_q   <= drained_d;
    end
  end

  assign bus.oIssueReady = issue_rdy;
  assign bus.oInflight   = inflight_q;
  assign bus.oStallCnt   = stall_cnt_q;
  assign bus.oErr        = err_q;
  assign bus.oDrained    = drained_q;

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue controller between InstDecoder and the ALU/regFile datapath.
- Decides each cycle whether the decoded instruction may issue. It tracks pending destination registers in a scoreboard, limits in-flight instructions, enforces flush bubbles and supports a drain request.
- Writeback from the datapath clears scoreboard entries.

Parameters:
- MAX_INFLIGHT, 4: maximum issued-but-not-written-back instructions (1..15).
- FLUSH_CYCLES, 2: bubble length after iFlush (1..7).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iIssueValid  in  1  decoder presents an instruction.
- oIssueReady  out  1  instruction accepted this cycle when iIssueValid=1.
- iRs1Addr  in  5  source register 1.
- iRs2Addr  in  5  source register 2.
- iUsesRs1  in  1  instruction reads rs1.
- iUsesRs2  in  1  instruction reads rs2.
- iRdAddr  in  5  destination register.
- iRdWe  in  1  instruction writes rd.
- iWbValid  in  1  writeback occurring.
- iWbAddr  in  5  writeback register.
- iFlush  in  1  branch/redirect flush pulse.
- iDrainReq  in  1  level; stop issuing and drain.
- oDrained  out  1  drain complete.
- oInflight  out  4  current in-flight count.
- oStallCnt  out  32  saturating count of stalled cycles.
- oErr  out  1  sticky; writeback with oInflight=0 or to a non-busy register.

Behaviour:
- Reset (async, iRst=1): busy[31:0]=0, inflight=0, state=RUN, flushCnt=0, oDrained=0, oStallCnt=0, oErr=0, oIssueReady=0 while iRst is high.
- Issue is combinational in the same cycle. An instruction fires when iIssueValid && oIssueReady.
- oIssueReady=1 only when all of the following hold:
  - state==RUN and iFlush==0.
  - inflight<MAX_INFLIGHT, or a writeback occurs this cycle.
  - No RAW hazard: (iUsesRs1 && busyEff[rs1]) or (iUsesRs2 && busyEff[rs2]) blocks.
  - No WAW hazard: (iRdWe && busyEff[rd]) blocks.
- busyEff = busy with the bit for iWbAddr cleared when iWbValid=1. This is the same-cycle writeback bypass.
- Register x0 is never busy: address 0 is never set and never causes a hazard. Writeback to x0 only decrements inflight.
- On the clock edge:
  - Fire with iRdWe and rd≠0 sets busy[rd].
  - iWbValid clears busy[iWbAddr].
  - If the same register is both set and cleared in one cycle, set wins.
- inflight:
  - +1 on fire, -1 on iWbValid; both in one cycle leaves it unchanged.
  - iWbValid with inflight==0 leaves it at 0 and sets oErr.
  - iWbValid to a register that is not busy (rd≠0) sets oErr.
- oStallCnt +1 each cycle with iIssueValid=1 && oIssueReady=0. It saturates at 0xFFFFFFFF.
- State machine:
  - RUN → FLUSH on iFlush=1. Any issue attempted that cycle is rejected. flushCnt loads FLUSH_CYCLES-1.
  - FLUSH: oIssueReady=0. Decrement flushCnt; go to RUN when flushCnt==0. iFlush in FLUSH reloads flushCnt.
  - RUN → DRAIN on iDrainReq=1 with iFlush=0. iFlush takes priority.
  - DRAIN: oIssueReady=0. oDrained=1 (registered) once inflight==0. Return to RUN when iDrainReq=0; oDrained drops in the same transition.
  - FLUSH → DRAIN is not direct: return to RUN first, then evaluate iDrainReq.
- Scoreboard and inflight are unaffected by flush. Older instructions still write back.
- Reset mid-operation discards all state immediately. No writeback is expected after reset.

Decomposition:
- corePckg additions:
  - tIssueState enum {RUN, FLUSH, DRAIN}.
  - cRegAddrW=5, cNumRegs=32.
  - tScoreboardCmd struct {set, setAddr, clr, clrAddr}.
- One sub-module, scoreboard: 32-bit busy vector, set/clear with set-priority, x0 hardwired 0, busyEff lookup for three addresses.
- issue_ctrl holds the FSM, inflight counter, stall counter and error flag.

Test Plan:
- Back-to-back independent issue: rd=1,2,3,4 with no sources, no writeback, MAX_INFLIGHT=4. Expect all four fire, oInflight=4. A fifth issue stalls and oStallCnt increments each cycle until iWbValid addr=1, which fires in that same cycle with oInflight staying 4.
- RAW plus bypass: issue rd=5, then rs1=5 with iUsesRs1=1. Expect a stall. Assert iWbValid addr=5 → ready=1 in that same cycle and busy[5]=0 afterwards.
- x0 handling: issue rd=0 iRdWe=1, then rs1=0 and rd=0. Expect no stall; busy stays 0; writeback to 0 decrements oInflight with oErr=0.
- Flush: iFlush pulse with FLUSH_CYCLES=2 while iIssueValid=1. Expect oIssueReady=0 for the flush cycle plus 2 cycles, then 1. Busy bits are preserved.
- Drain: two in flight, then iDrainReq=1. Expect oDrained=0 until the second writeback, oDrained=1 the next cycle, and no issues throughout. Dropping iDrainReq gives oDrained=0 and issue resumes.
- Error and reset: iWbValid with oInflight=0 → oErr=1 sticky. Assert iRst asynchronously mid-cycle → all outputs immediately return to reset values, including oErr=0 and oStallCnt=0.
